// File: rtl/vend_credit_controller.sv
// Credit-accumulating sequencer for the water vending datapath.
// Collects coins, hands off to the dispenser once the price is covered, then
// pays back remaining credit one unit at a time through the change unit.
module vend_credit_controller #(
    parameter int unsigned PRICE        = 3,
    parameter int unsigned MAX_CREDIT   = 9,
    parameter int unsigned CREDIT_W     = 4,
    parameter int unsigned DISP_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ONE,
    input  logic                TWO,
    input  logic                FIVE,
    input  logic                cancel,
    input  logic                disp_done,
    input  logic                chg_ack,
    output logic                disp_req,
    output logic                chg_req,
    output logic                water,
    output logic                change,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                fault
);

    localparam logic [1:0] ST_COLLECT  = 2'd0;
    localparam logic [1:0] ST_DISPENSE = 2'd1;
    localparam logic [1:0] ST_CHANGE   = 2'd2;

    localparam int unsigned TMO_W = $clog2(DISP_TIMEOUT + 1);

    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_SUM   = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(DISP_TIMEOUT - 1);

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                fault_q, fault_d;
    logic                water_q, water_d;
    logic                reject_q, reject_d;

    logic                any_coin;
    logic                multi_coin;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;

    // Coin decode: highest-value coin wins, any extra coin is a rejection
    always_comb begin
        any_coin   = ONE | TWO | FIVE;
        multi_coin = (FIVE & (TWO | ONE)) | (TWO & ONE);
        if (FIVE) begin
            coin_val = (CREDIT_W + 1)'(5);
        end else if (TWO) begin
            coin_val = (CREDIT_W + 1)'(2);
        end else if (ONE) begin
            coin_val = (CREDIT_W + 1)'(1);
        end else begin
            coin_val = '0;
        end
        // One extra bit so an overflowing sum is still compared correctly
        coin_sum = {1'b0, credit_q} + coin_val;
    end

    // Next-state, credit, timeout and pulse computation
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        tmo_d    = tmo_q;
        fault_d  = fault_q;
        water_d  = 1'b0;
        reject_d = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                // Counter is held clear so DISPENSE always starts from zero
                tmo_d = '0;
                if (cancel && (credit_q != '0)) begin
                    state_d  = ST_CHANGE;
                    reject_d = any_coin;
                end else begin
                    reject_d = multi_coin;
                    if (any_coin) begin
                        if (coin_sum <= MAX_SUM) begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                    // Decision uses registered credit, not this cycle's coin
                    if (credit_q >= PRICE_C) begin
                        state_d = ST_DISPENSE;
                    end
                end
            end
            ST_DISPENSE: begin
                reject_d = any_coin;
                if (disp_done) begin
                    credit_d = credit_q - PRICE_C;
                    water_d  = 1'b1;
                    state_d  = (credit_q != PRICE_C) ? ST_CHANGE : ST_COLLECT;
                end else if (tmo_q == TMO_LAST) begin
                    // Dispenser never answered: refund everything
                    fault_d = 1'b1;
                    state_d = ST_CHANGE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_CHANGE: begin
                reject_d = any_coin;
                if (chg_ack) begin
                    credit_d = credit_q - 1'b1;
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_COLLECT;
            credit_q <= '0;
            tmo_q    <= '0;
            fault_q  <= 1'b0;
            water_q  <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            tmo_q    <= tmo_d;
            fault_q  <= fault_d;
            water_q  <= water_d;
            reject_q <= reject_d;
        end
    end

    // Outputs decode registers only; no input-to-output combinational path
    always_comb begin
        disp_req    = (state_q == ST_DISPENSE);
        chg_req     = (state_q == ST_CHANGE);
        change      = (state_q == ST_CHANGE);
        busy        = (state_q != ST_COLLECT);
        credit      = credit_q;
        water       = water_q;
        coin_reject = reject_q;
        fault       = fault_q;
    end

endmodule

// File: tb/tb_vend_credit_controller.sv
// Self-checking bench for vend_credit_controller: directed scenarios plus a
// randomized run, all compared against a behavioural model of the vending rules.
module tb_vend_credit_controller;

    localparam int PRICE        = 3;
    localparam int MAX_CREDIT   = 9;
    localparam int CREDIT_W     = 4;
    localparam int DISP_TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic one = 1'b0, two = 1'b0, five = 1'b0, cancel = 1'b0;
    logic disp_done = 1'b0, chg_ack = 1'b0;
    logic disp_req, chg_req, water, change, busy, coin_reject, fault;
    logic [CREDIT_W-1:0] credit;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 = collecting, 1 = dispensing, 2 = paying change
    int m_mode, m_credit, m_disp_cycles;
    bit m_fault, m_water, m_rej;
    int water_cnt, chg_cnt;

    always #5 clk = ~clk;

    vend_credit_controller #(
        .PRICE       (PRICE),
        .MAX_CREDIT  (MAX_CREDIT),
        .CREDIT_W    (CREDIT_W),
        .DISP_TIMEOUT(DISP_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ONE        (one),
        .TWO        (two),
        .FIVE       (five),
        .cancel     (cancel),
        .disp_done  (disp_done),
        .chg_ack    (chg_ack),
        .disp_req   (disp_req),
        .chg_req    (chg_req),
        .water      (water),
        .change     (change),
        .credit     (credit),
        .busy       (busy),
        .coin_reject(coin_reject),
        .fault      (fault)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_flags();
        return {disp_req, chg_req, change, busy, water, coin_reject, fault};
    endfunction

    function automatic logic [6:0] model_flags();
        return {m_mode == 1, m_mode == 2, m_mode == 2, m_mode != 0, m_water, m_rej, m_fault};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_credit = 0; m_disp_cycles = 0;
        m_fault = 0; m_water = 0; m_rej = 0;
    endtask

    // One clock of the vending rules, applied to the inputs present at the edge
    task automatic model_update();
        int coins, value, nxt_mode;
        coins = int'(one) + int'(two) + int'(five);
        value = five ? 5 : (two ? 2 : (one ? 1 : 0));
        m_water = 0;
        m_rej   = 0;
        nxt_mode = m_mode;
        if (m_mode == 0) begin
            if (cancel && m_credit > 0) begin
                m_rej = (coins > 0);
                nxt_mode = 2;
            end else begin
                if (m_credit >= PRICE) begin
                    nxt_mode = 1;
                    m_disp_cycles = 1;
                end
                if (coins > 1) m_rej = 1;
                if (value > 0) begin
                    if (m_credit + value <= MAX_CREDIT) m_credit += value;
                    else m_rej = 1;
                end
            end
        end else if (m_mode == 1) begin
            m_rej = (coins > 0);
            if (disp_done) begin
                m_credit -= PRICE;
                m_water = 1;
                water_cnt++;
                nxt_mode = (m_credit > 0) ? 2 : 0;
            end else if (m_disp_cycles == DISP_TIMEOUT) begin
                m_fault = 1;
                nxt_mode = 2;
            end else begin
                m_disp_cycles++;
            end
        end else begin
            m_rej = (coins > 0);
            if (chg_ack) begin
                m_credit -= 1;
                chg_cnt++;
                if (m_credit == 0) nxt_mode = 0;
            end
        end
        m_mode = nxt_mode;
    endtask

    // Called at a negedge: drive, clock, update model, compare at next negedge
    task automatic step(input logic o, input logic t, input logic f, input logic c,
                        input logic d, input logic a);
        one = o; two = t; five = f; cancel = c; disp_done = d; chg_ack = a;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("credit", credit, m_credit);
        check("flags", dut_flags(), model_flags());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        water_cnt = 0; chg_cnt = 0;
        repeat (2) @(negedge clk);
        check("reset_credit", credit, 0);
        check("reset_flags", dut_flags(), 0);
        reset = 1'b1;

        // ONE at c0, TWO at c2: dispense, exact price, no change
        water_cnt = 0; chg_cnt = 0;
        step(1, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 0, 0, 0, 0);
        idle(3);
        check("s1_disp_req", disp_req, 1);
        step(0, 0, 0, 0, 1, 0);
        check("s1_water", water, 1);
        check("s1_busy", busy, 0);
        idle(1);
        check("s1_water_once", water, 0);
        check("s1_chg_units", chg_cnt, 0);

        // FIVE: dispense then two change units
        water_cnt = 0; chg_cnt = 0;
        step(0, 0, 1, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 0);
        check("s2_chg_req", chg_req, 1);
        check("s2_credit", credit, 2);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("s2_chg_units", chg_cnt, 2);
        check("s2_busy", busy, 0);

        // TWO+FIVE together, then ONE while dispensing
        step(0, 1, 1, 0, 0, 0);
        check("s3_credit", credit, 5);
        check("s3_reject", coin_reject, 1);
        idle(1);
        check("s3_reject_pulse", coin_reject, 0);
        step(1, 0, 0, 0, 0, 0);
        check("s3_reject_disp", coin_reject, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // FIVE with a silent dispenser: timeout, full refund, sticky fault
        water_cnt = 0; chg_cnt = 0;
        step(0, 0, 1, 0, 0, 0);
        idle(1 + DISP_TIMEOUT);
        check("s4_fault", fault, 1);
        check("s4_chg_req", chg_req, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
        idle(2);
        check("s4_credit0", credit, 0);
        check("s4_water_cnt", water_cnt, 0);
        check("s4_fault_sticky", fault, 1);

        // ONE, ONE, then cancel with TWO: refund 2
        chg_cnt = 0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        check("s5_reject", coin_reject, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("s5_chg_units", chg_cnt, 2);

        // Async reset in the middle of CHANGE with credit 3
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("s6_pre_chg", chg_req, 1);
        #2 reset = 1'b0;
        #1;
        check("s6_rst_credit", credit, 0);
        check("s6_rst_flags", dut_flags(), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
